// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the M-stage data-access controller: opcodes, bus
// size encodings and the handshake FSM state type.
package mem_access_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational data-path helper: request encoding (size, strobes, lane
// replicated store data, alignment faults) and load-data lane select/extension.
module mem_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] writedata,
    input  logic [5:0]  ld_op,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic        is_mem,
    output logic        is_store,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        adel,
    output logic        ades
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        is_mem   = 1'b0;
        is_store = 1'b0;
        size     = SZ_B;
        wstrb    = 4'b0000;
        wdata    = writedata;
        adel     = 1'b0;
        ades     = 1'b0;
        case (op)
            OP_LB, OP_LBU: begin
                is_mem = 1'b1;
            end
            OP_LH, OP_LHU: begin
                is_mem = 1'b1;
                size   = SZ_H;
                adel   = addr_lo[0];
            end
            OP_LW: begin
                is_mem = 1'b1;
                size   = SZ_W;
                adel   = |addr_lo;
            end
            OP_SB: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                wstrb    = 4'b0001 << addr_lo;
                wdata    = {4{writedata[7:0]}};
            end
            OP_SH: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                size     = SZ_H;
                wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{writedata[15:0]}};
                ades     = addr_lo[0];
            end
            OP_SW: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                size     = SZ_W;
                wstrb    = 4'b1111;
                ades     = |addr_lo;
            end
            default: ;
        endcase
    end

    // Load side works on the registered request, not on the live M-stage inputs.
    always_comb begin
        case (ld_addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (ld_op)
            OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_data = {24'd0, byte_sel};
            OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ld_data = {16'd0, half_sel};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage load/store controller: single-outstanding SRAM-like bus sequencer
// with alignment faults, flush cancellation and pipeline stall generation.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validM,
    input  logic [5:0]        opM,
    input  logic [ADDR_W-1:0] addrM,
    input  logic [31:0]       writedataM,
    input  logic              flushM,
    input  logic              advanceM,
    output logic              stallM,
    output logic [31:0]       readdataM,
    output logic              adelM,
    output logic              adesM,
    output logic [ADDR_W-1:0] badvaddrM,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);

    state_t            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [5:0]        op_q, op_d;
    logic [31:0]       rdata_q, rdata_d;

    logic        al_is_mem, al_is_store, al_adel, al_ades;
    logic [1:0]  al_size;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata, al_ld_data;
    logic        start, complete;

    mem_align u_align (
        .op         (opM),
        .addr_lo    (addrM[1:0]),
        .writedata  (writedataM),
        .ld_op      (op_q),
        .ld_addr_lo (addr_q[1:0]),
        .rdata      (data_rdata),
        .is_mem     (al_is_mem),
        .is_store   (al_is_store),
        .size       (al_size),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .ld_data    (al_ld_data),
        .adel       (al_adel),
        .ades       (al_ades)
    );

    assign adelM     = validM & al_adel;
    assign adesM     = validM & al_ades;
    assign badvaddrM = addrM;
    assign start     = validM & al_is_mem & ~adelM & ~adesM & ~flushM;
    assign complete  = ((state_q == ST_REQ) & data_addr_ok & data_data_ok) |
                       ((state_q == ST_WAIT) & data_data_ok);

    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        wr_d     = wr_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        op_d     = op_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_REQ;
                    cancel_d = 1'b0;
                    wr_d     = al_is_store;
                    size_d   = al_size;
                    addr_d   = addrM;
                    wstrb_d  = al_wstrb;
                    wdata_d  = al_wdata;
                    op_d     = opM;
                end
            end
            ST_REQ: begin
                // The request stays up until accepted even when flushed.
                if (flushM) cancel_d = 1'b1;
                if (data_addr_ok && !data_data_ok) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flushM) cancel_d = 1'b1;
            end
            ST_DONE: begin
                if (flushM || advanceM) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (complete) begin
            if (cancel_q || flushM) begin
                state_d  = ST_IDLE;
                cancel_d = 1'b0;
            end else begin
                state_d = ST_DONE;
                if (!wr_q) rdata_d = al_ld_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cancel_q <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
            op_q     <= 6'd0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            op_q     <= op_d;
            rdata_q  <= rdata_d;
        end
    end

    assign data_req   = (state_q == ST_REQ);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;
    assign readdataM  = rdata_q;
    assign stallM     = ((state_q == ST_IDLE) & start) | (state_q == ST_REQ) | (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, hand-written reset and
// flush sequences, and randomized transactions against a byte-lane model.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk, rst, validM, flushM, advanceM;
    logic [5:0]  opM;
    logic [31:0] addrM, writedataM, readdataM, badvaddrM;
    logic        stallM, adelM, adesM;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;

    int checks = 0;
    int errors = 0;
    logic [31:0] cur_rd = 32'd0;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .validM(validM), .opM(opM), .addrM(addrM),
        .writedataM(writedataM), .flushM(flushM), .advanceM(advanceM),
        .stallM(stallM), .readdataM(readdataM), .adelM(adelM), .adesM(adesM),
        .badvaddrM(badvaddrM), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr, wd, rd;
        int          a_lat, d_lat, flush_at;
        bit          flush_done;
        bit          exp_mem, exp_wr, exp_adel, exp_ades;
        logic [1:0]  exp_size;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata, exp_ld;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] addr, wd, rd,
                                input int a, d, fl, input bit fd, input bit mem, wr, adel, ades,
                                input logic [1:0] sz, input logic [3:0] ws,
                                input logic [31:0] wdat, ld);
        vec_t v;
        v.op = op; v.addr = addr; v.wd = wd; v.rd = rd;
        v.a_lat = a; v.d_lat = d; v.flush_at = fl; v.flush_done = fd;
        v.exp_mem = mem; v.exp_wr = wr; v.exp_adel = adel; v.exp_ades = ades;
        v.exp_size = sz; v.exp_wstrb = ws; v.exp_wdata = wdat; v.exp_ld = ld;
        return v;
    endfunction

    // Reference model: access width in bytes drives every expectation.
    function automatic vec_t model(input logic [5:0] op, input logic [31:0] addr, wd, rd,
                                   input int a, d, fl, input bit fd);
        vec_t v;
        int nb, lane;
        bit sgn, wr, mis;
        logic [31:0] mask, val;
        nb = 0; sgn = 0; wr = 0;
        case (op)
            6'b100000: begin nb = 1; sgn = 1; end
            6'b100001: begin nb = 2; sgn = 1; end
            6'b100011: nb = 4;
            6'b100100: nb = 1;
            6'b100101: nb = 2;
            6'b101000: begin nb = 1; wr = 1; end
            6'b101001: begin nb = 2; wr = 1; end
            6'b101011: begin nb = 4; wr = 1; end
            default:   nb = 0;
        endcase
        lane = int'(addr % 4);
        mis  = (nb != 0) && ((lane % nb) != 0);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        val  = (rd >> (8 * lane)) & mask;
        if (sgn && val[8 * nb - 1]) val = val | ~mask;
        v = mk(op, addr, wd, rd, a, d, fl, fd, nb != 0, wr, mis && !wr, mis && wr,
               (nb == 4) ? 2'd2 : (nb == 2) ? 2'd1 : 2'd0,
               wr ? 4'(((1 << nb) - 1) << lane) : 4'd0,
               (nb == 1) ? wd[7:0] * 32'h0101_0101 : (nb == 2) ? wd[15:0] * 32'h0001_0001 : wd,
               val);
        return v;
    endfunction

    task automatic idle_inputs();
        validM = 0; opM = 6'd0; addrM = 32'd0; writedataM = 32'd0; flushM = 0;
        advanceM = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'd0;
    endtask

    // One M-stage instruction: cycle 0 presents it, cycles 1..last are the
    // REQ then WAIT cycles, followed by DONE (or IDLE when cancelled).
    task automatic txn(input vec_t v);
        int  last;
        bit  starts, in_req, cancelled;
        last = v.a_lat + 1 + v.d_lat;
        @(posedge clk); #1;
        validM = 1; opM = v.op; addrM = v.addr; writedataM = v.wd;
        flushM = (v.flush_at == 0); advanceM = 0; data_addr_ok = 0; data_data_ok = 0;
        starts = v.exp_mem && !v.exp_adel && !v.exp_ades && (v.flush_at != 0);
        @(negedge clk);
        chk("adelM", 32'(adelM), 32'(v.exp_adel));
        chk("adesM", 32'(adesM), 32'(v.exp_ades));
        chk("badvaddrM", badvaddrM, v.addr);
        chk("idle_req", 32'(data_req), 32'd0);
        chk("idle_stall", 32'(stallM), 32'(starts));
        if (!starts) begin
            @(posedge clk); #1;
            validM = 0; flushM = 0;
            @(negedge clk);
            chk("noreq_req", 32'(data_req), 32'd0);
            chk("noreq_state", 32'(dut.state_q), 32'(ST_IDLE));
            return;
        end
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            flushM = (k == v.flush_at);
            if (v.flush_at >= 1 && k > v.flush_at) validM = 0;
            in_req = (k <= v.a_lat + 1);
            data_addr_ok = in_req ? (k == v.a_lat + 1) : 1'($urandom_range(0, 1));
            data_data_ok = (k == last);
            data_rdata   = (k == last) ? v.rd : $urandom;
            @(negedge clk);
            chk("busy_req", 32'(data_req), 32'(in_req));
            chk("busy_stall", 32'(stallM), 32'd1);
            if (in_req) begin
                chk("data_wr", 32'(data_wr), 32'(v.exp_wr));
                chk("data_size", 32'(data_size), 32'(v.exp_size));
                chk("data_addr", data_addr, v.addr);
                chk("data_wstrb", 32'(data_wstrb), 32'(v.exp_wstrb));
                if (v.exp_wr) chk("data_wdata", data_wdata, v.exp_wdata);
            end
        end
        cancelled = (v.flush_at >= 1);
        @(posedge clk); #1;
        flushM = 0; data_addr_ok = 0;
        data_data_ok = 1'($urandom_range(0, 1)); data_rdata = $urandom;
        if (cancelled) validM = 0;
        else if (!v.exp_wr) cur_rd = v.exp_ld;
        advanceM = !cancelled && !v.flush_done;
        flushM   = !cancelled && v.flush_done;
        @(negedge clk);
        chk("end_readdata", readdataM, cur_rd);
        chk("end_req", 32'(data_req), 32'd0);
        chk("end_stall", 32'(stallM), 32'd0);
        chk("end_state", 32'(dut.state_q), cancelled ? 32'(ST_IDLE) : 32'(ST_DONE));
        @(posedge clk); #1;
        validM = 0; advanceM = 0; flushM = 0; data_data_ok = 0;
        @(negedge clk);
        chk("after_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("after_req", 32'(data_req), 32'd0);
        chk("after_readdata", readdataM, cur_rd);
    endtask

    vec_t        vecs[$];
    logic [5:0]  rops[11];

    initial begin
        vecs.push_back(mk(OP_LW,  32'h1000, 32'h0, 32'hDEADBEEF, 1, 1, -1, 0, 1, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'hDEADBEEF));
        vecs.push_back(mk(OP_LB,  32'h1003, 32'h0, 32'h80FFFF00, 0, 0, -1, 0, 1, 0, 0, 0, SZ_B, 4'h0, 32'h0, 32'hFFFFFF80));
        vecs.push_back(mk(OP_LBU, 32'h1003, 32'h0, 32'h80FFFF00, 0, 2, -1, 0, 1, 0, 0, 0, SZ_B, 4'h0, 32'h0, 32'h00000080));
        vecs.push_back(mk(OP_SB,  32'h2002, 32'hAB, 32'h0, 1, 0, -1, 0, 1, 1, 0, 0, SZ_B, 4'h4, 32'hABABABAB, 32'h0));
        vecs.push_back(mk(OP_SH,  32'h2002, 32'h1234CDEF, 32'h0, 0, 1, -1, 0, 1, 1, 0, 0, SZ_H, 4'hC, 32'hCDEFCDEF, 32'h0));
        vecs.push_back(mk(OP_LH,  32'h3001, 32'h0, 32'h0, 0, 0, -1, 0, 1, 0, 1, 0, SZ_H, 4'h0, 32'h0, 32'h0));
        vecs.push_back(mk(OP_SW,  32'h3002, 32'h0, 32'h0, 0, 0, -1, 0, 1, 1, 0, 1, SZ_W, 4'hF, 32'h0, 32'h0));
        vecs.push_back(mk(OP_LW,  32'h1004, 32'h0, 32'h12345678, 0, 2, 2, 0, 1, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'h12345678));
        vecs.push_back(mk(OP_LH,  32'h3002, 32'h0, 32'h80017FFF, 0, 0, -1, 0, 1, 0, 0, 0, SZ_H, 4'h0, 32'h0, 32'hFFFF8001));
        vecs.push_back(mk(OP_LHU, 32'h3000, 32'h0, 32'h80017FFF, 2, 1, -1, 0, 1, 0, 0, 0, SZ_H, 4'h0, 32'h0, 32'h00007FFF));
        vecs.push_back(mk(OP_SW,  32'h400C, 32'hCAFEF00D, 32'h0, 0, 0, -1, 0, 1, 1, 0, 0, SZ_W, 4'hF, 32'hCAFEF00D, 32'h0));
        vecs.push_back(mk(OP_LW,  32'h5000, 32'h0, 32'hA5A5A5A5, 2, 1, 1, 0, 1, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'hA5A5A5A5));
        vecs.push_back(mk(OP_LW,  32'h5004, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, SZ_W, 4'h0, 32'h0, 32'h0));
        vecs.push_back(mk(6'b100010, 32'h6001, 32'h0, 32'h0, 0, 0, -1, 0, 0, 0, 0, 0, SZ_B, 4'h0, 32'h0, 32'h0));
        vecs.push_back(mk(OP_LB,  32'h6001, 32'h0, 32'h00007F00, 1, 0, -1, 1, 1, 0, 0, 0, SZ_B, 4'h0, 32'h0, 32'h0000007F));
        vecs.push_back(mk(OP_SH,  32'h2001, 32'h0, 32'h0, 0, 0, -1, 0, 1, 1, 0, 1, SZ_H, 4'h3, 32'h0, 32'h0));
        vecs.push_back(mk(OP_LW,  32'h2002, 32'h0, 32'h0, 0, 0, -1, 0, 1, 0, 1, 0, SZ_W, 4'h0, 32'h0, 32'h0));
        rops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
                 6'b100010, 6'b001000, 6'b101110};

        // Reset state
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_wr", 32'(data_wr), 32'd0);
        chk("rst_size", 32'(data_size), 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_wstrb", 32'(data_wstrb), 32'd0);
        chk("rst_wdata", data_wdata, 32'd0);
        chk("rst_readdata", readdataM, 32'd0);
        chk("rst_stall", 32'(stallM), 32'd0);
        @(posedge clk); #1;
        rst = 0;

        foreach (vecs[i]) txn(vecs[i]);

        // Asynchronous reset while the request is outstanding
        @(posedge clk); #1;
        validM = 1; opM = OP_LW; addrM = 32'h7000; flushM = 0;
        @(posedge clk); #1;
        validM = 0;
        chk("arst_pre_req", 32'(data_req), 32'd1);
        #2 rst = 1;
        #1;
        chk("arst_req", 32'(data_req), 32'd0);
        chk("arst_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("arst_readdata", readdataM, 32'd0);
        chk("arst_addr", data_addr, 32'd0);
        cur_rd = 32'd0;
        #2 rst = 0;
        txn(model(OP_LW, 32'h7004, 32'h0, 32'h0BADF00D, 1, 1, -1, 0));

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int al, dl, fl, last;
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            al = $urandom_range(0, 3);
            dl = $urandom_range(0, 3);
            last = al + 1 + dl;
            fl = -1;
            if ($urandom_range(0, 9) == 0) fl = 0;
            else if (last >= 2 && $urandom_range(0, 4) == 0) fl = $urandom_range(1, last - 1);
            txn(model(rops[$urandom_range(0, 10)], a, $urandom, $urandom, al, dl, fl,
                      1'($urandom_range(0, 3) == 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
